// File: rtl/clk_en_pkg.sv
// Shared types and helpers for the clock-enable generator.
package clk_en_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam int unsigned SYNC_STAGES = 2;

  // Rounded phase increment for f_ce out of f_clk, e.g. 90 MHz -> 27 MHz at 32 bits gives 1288490189.
  function automatic longint unsigned inc_for(input longint unsigned f_clk_hz,
                                               input longint unsigned f_ce_hz,
                                               input int unsigned     acc_w);
    return ((f_ce_hz << acc_w) + (f_clk_hz >> 1)) / f_clk_hz;
  endfunction

endpackage

// File: rtl/clk_en_acc.sv
// One fractional clock-enable channel: phase accumulator plus a shadowed increment
// that only swaps on a carry edge (or when idle / stalled at zero) to keep phase continuous.
module clk_en_acc
  import clk_en_pkg::*;
#(
  parameter int unsigned      ACC_W   = 32,
  parameter logic [ACC_W-1:0] INC_RST = '0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             in_run,
  input  logic             advance,
  input  logic             cfg_we,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic             ce,
  output logic             pending_nxt_c
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] shadow;
  logic             pending;
  logic [ACC_W:0]   sum_c;
  logic             carry_c;
  logic             apply_c;

  always_comb begin
    sum_c         = {1'b0, acc} + {1'b0, inc};
    carry_c       = advance & sum_c[ACC_W];
    apply_c       = pending & (~in_run | (inc == '0) | carry_c);
    // A write landing on the apply edge keeps the flag so the newer value follows later.
    pending_nxt_c = cfg_we | (pending & ~apply_c);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc     <= '0;
      inc     <= INC_RST;
      shadow  <= '0;
      pending <= 1'b0;
      ce      <= 1'b0;
    end else begin
      acc     <= advance ? sum_c[ACC_W-1:0] : '0;
      ce      <= carry_c;
      pending <= pending_nxt_c;
      if (apply_c) inc    <= shadow;
      if (cfg_we)  shadow <= cfg_inc;
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator gated on a debounced PLL lock.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int unsigned                CHANNELS    = 2,
  parameter int unsigned                ACC_W       = 32,
  parameter int unsigned                LOCK_CYCLES = 1024,
  parameter logic [CHANNELS*ACC_W-1:0]  INC_INIT    = '0,
  localparam int unsigned               CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                pll_locked,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  output logic                cfg_busy,
  output logic [CHANNELS-1:0] ce,
  output logic                locked
);

  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s_lock;
  logic                   in_run_c;
  logic                   advance_c;
  logic [CHANNELS-1:0]    ch_we;
  logic [CHANNELS-1:0]    pend_nxt;

  assign s_lock    = sync[SYNC_STAGES-1];
  assign in_run_c  = (state == RUN);
  // Accumulators freeze to zero on the same edge that leaves RUN.
  assign advance_c = in_run_c & s_lock;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync     <= '0;
      state    <= IDLE;
      cnt      <= '0;
      locked   <= 1'b0;
      cfg_busy <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], pll_locked};
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      locked   <= (state_nxt == RUN);
      cfg_busy <= |pend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (s_lock) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!s_lock) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!s_lock) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Out-of-range channel selects match no channel and are dropped.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign ch_we[k] = cfg_we & (cfg_ch == CW'(k));

    clk_en_acc #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_INIT[k*ACC_W +: ACC_W])
    ) u_acc (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .in_run        (in_run_c),
      .advance       (advance_c),
      .cfg_we        (ch_we[k]),
      .cfg_inc       (cfg_inc),
      .ce            (ce[k]),
      .pending_nxt_c (pend_nxt[k])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: lock sequencing, pulse trains, reprogramming, reset.
module tb_clk_en_gen;

  localparam int unsigned ACC_W       = 8;
  localparam int unsigned CHANNELS    = 2;
  localparam int unsigned LOCK_CYCLES = 4;
  localparam logic [15:0] INC_INIT    = {8'd128, 8'd77};
  localparam logic [23:0] INC_INIT3   = {8'd10, 8'd20, 8'd30};

  typedef struct packed {
    logic [1:0] mask;
    logic [1:0] ce;
  } exp_t;

  logic clk_sys = 1'b0;
  logic reset;
  logic pll_locked;
  logic cfg_we;
  logic cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic cfg_busy;
  logic [CHANNELS-1:0] ce;
  logic locked;

  logic pll_locked2;
  logic cfg_we2;
  logic [1:0] cfg_ch2;
  logic [ACC_W-1:0] cfg_inc2;
  logic busy2;
  logic [2:0] ce2;
  logic locked2;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  int ch0_cnt = 0;
  int run_n = 0;
  bit track = 1'b0;

  always #5 clk_sys = ~clk_sys;

  clk_en_gen #(
    .CHANNELS(CHANNELS), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK_CYCLES), .INC_INIT(INC_INIT)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .pll_locked(pll_locked), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_busy(cfg_busy), .ce(ce), .locked(locked)
  );

  clk_en_gen #(
    .CHANNELS(3), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK_CYCLES), .INC_INIT(INC_INIT3)
  ) dut3 (
    .clk_sys(clk_sys), .reset(reset), .pll_locked(pll_locked2), .cfg_we(cfg_we2),
    .cfg_ch(cfg_ch2), .cfg_inc(cfg_inc2), .cfg_busy(busy2), .ce(ce2), .locked(locked2)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] mask, input logic [1:0] val);
    exp_q.push_back({mask, val});
  endtask

  // One clock: sample after the edge, score any queued expectation.
  task automatic step();
    exp_t e;
    @(posedge clk_sys);
    #1;
    if (track) begin
      run_n++;
      ch0_cnt += int'(ce[0]);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ce_sb", int'(ce & e.mask), int'(e.ce & e.mask));
    end
  endtask

  task automatic wait_lock(output int edges, output int ce_seen);
    edges = 0;
    ce_seen = 0;
    while (edges < 40) begin
      step();
      edges++;
      ce_seen += int'(ce != '0);
      if (locked) break;
    end
  endtask

  task automatic cfg_write(input logic ch, input logic [ACC_W-1:0] val);
    cfg_we = 1'b1;
    cfg_ch = ch;
    cfg_inc = val;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int seen;
    int n1;
    reset = 1'b1;
    pll_locked = 1'b0;
    cfg_we = 1'b0;
    cfg_ch = 1'b0;
    cfg_inc = '0;
    pll_locked2 = 1'b0;
    cfg_we2 = 1'b0;
    cfg_ch2 = '0;
    cfg_inc2 = '0;

    repeat (3) step();
    check("rst_ce", int'(ce), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_busy", int'(cfg_busy), 0);
    reset = 1'b0;
    repeat (2) step();
    check("idle_locked", int'(locked), 0);

    // Lock sequencing and steady pulse trains
    pll_locked = 1'b1;
    wait_lock(edges, seen);
    check("lock_latency", edges, 7);
    check("settle_ce", seen, 0);
    track = 1'b1;
    ch0_cnt = 0;
    run_n = 0;
    for (int i = 0; i < 100; i++) push_exp(2'b10, (i % 2 == 1) ? 2'b10 : 2'b00);
    repeat (100) step();
    check("ch0_100", ch0_cnt, 30);

    // Reprogram ch1 to 64 between pulses
    cfg_write(1'b1, 8'd64);
    check("busy_set", int'(cfg_busy), 1);
    check("ce1_at_wr", int'(ce[1]), 0);
    step();
    check("busy_clr", int'(cfg_busy), 0);
    check("ce1_apply", int'(ce[1]), 1);
    for (int i = 0; i < 8; i++) push_exp(2'b10, (i % 4 == 3) ? 2'b10 : 2'b00);
    repeat (8) step();
    check("ch0_total_a", ch0_cnt, run_n * 77 / 256);

    // inc=0 silences the channel; a later write applies on the next edge
    cfg_write(1'b1, 8'd0);
    check("busy_z", int'(cfg_busy), 1);
    n1 = 0;
    while (cfg_busy && n1 < 300) begin
      step();
      n1++;
    end
    check("busy_z_drop", int'(cfg_busy), 0);
    n1 = 0;
    repeat (1000) begin
      step();
      n1 += int'(ce[1]);
    end
    check("inc0_pulses", n1, 0);
    cfg_write(1'b1, 8'hFF);
    check("busy_ff", int'(cfg_busy), 1);
    step();
    check("apply_ff_next", int'(cfg_busy), 0);
    check("ce1_ff_first", int'(ce[1]), 0);
    n1 = 0;
    repeat (256) begin
      step();
      n1 += int'(ce[1]);
    end
    check("inc255_pulses", n1, 255);
    check("ch0_total_b", ch0_cnt, run_n * 77 / 256);

    // Lock loss in RUN
    pll_locked = 1'b0;
    track = 1'b0;
    edges = 0;
    while ((locked || ce != '0) && edges < 10) begin
      step();
      edges++;
    end
    check("unlock_edges", edges, 3);
    n1 = 0;
    repeat (5) begin
      step();
      n1 += int'(ce != '0) + int'(locked);
    end
    check("unlock_quiet", n1, 0);

    // Short lock glitch, then a real lock
    n1 = 0;
    pll_locked = 1'b1;
    repeat (3) begin
      step();
      n1 += int'(locked) + int'(ce != '0);
    end
    pll_locked = 1'b0;
    repeat (2) begin
      step();
      n1 += int'(locked) + int'(ce != '0);
    end
    pll_locked = 1'b1;
    wait_lock(edges, seen);
    check("glitch_quiet", n1 + seen, 0);
    check("glitch_latency", edges, 7);
    // Accumulators restart from zero: ch1 inc=255, ch0 inc=77
    push_exp(2'b11, 2'b00);
    push_exp(2'b11, 2'b10);
    push_exp(2'b11, 2'b10);
    push_exp(2'b11, 2'b11);
    repeat (4) step();

    // Reset with a write still pending
    cfg_write(1'b0, 8'd200);
    check("busy_pre_rst", int'(cfg_busy), 1);
    reset = 1'b1;
    step();
    check("rst2_ce", int'(ce), 0);
    check("rst2_locked", int'(locked), 0);
    check("rst2_busy", int'(cfg_busy), 0);
    reset = 1'b0;
    wait_lock(edges, seen);
    check("rst2_latency", edges, 7);
    push_exp(2'b11, 2'b00);
    push_exp(2'b11, 2'b10);
    push_exp(2'b11, 2'b00);
    push_exp(2'b11, 2'b11);
    repeat (4) step();
    check("rst2_busy_after", int'(cfg_busy), 0);

    // Out-of-range channel on a three-channel instance
    cfg_ch2 = 2'd3;
    cfg_inc2 = 8'd99;
    cfg_we2 = 1'b1;
    step();
    cfg_we2 = 1'b0;
    check("oor_busy", int'(busy2), 0);
    cfg_ch2 = 2'd2;
    cfg_we2 = 1'b1;
    step();
    cfg_we2 = 1'b0;
    check("inrange_busy", int'(busy2), 1);
    step();
    check("inrange_apply", int'(busy2), 0);
    check("dut3_idle", int'(ce2) + int'(locked2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
